// File: rtl/spi_rm3100_target_if.sv
// SPI pins plus local load / write-commit bus of the RM3100-style SPI target.
`timescale 1ns/1ps
interface spi_rm3100_target_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       ld_en;
  logic [6:0] ld_addr;
  logic [7:0] ld_data;
  logic       wr_stb;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  modport slave (
    input  sclk, cs_n, mosi, ld_en, ld_addr, ld_data,
    output miso, miso_oe, wr_stb, wr_addr, wr_data
  );

  modport master (
    output sclk, cs_n, mosi, ld_en, ld_addr, ld_data,
    input  miso, miso_oe, wr_stb, wr_addr, wr_data
  );
endinterface

// File: rtl/spi_rm3100_target.sv
// Mode-3 SPI target emulating the RM3100 register interface: command byte {rw, addr}
// followed by auto-incrementing data bytes, with a local load port into the register bank.
//
// state | meaning
// IDLE  | chip select high, outputs quiet
// CMD   | shifting in the command byte
// DATA  | write: shifting data bytes in; read: shifting register bytes out on miso
`timescale 1ns/1ps
module spi_rm3100_target #(
  parameter int DEPTH   = 16,
  parameter int SYNC_FF = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_rm3100_target_if.slave   bus,
  output logic                 busy_o
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  logic [SYNC_FF-1:0] sclk_sync_q;
  logic [SYNC_FF-1:0] cs_sync_q;
  logic [SYNC_FF-1:0] mosi_sync_q;
  logic               sclk_prev_q;
  logic               sclk_s, cs_s, mosi_s;
  logic               sclk_rise, sclk_fall;

  state_t     state_q;
  logic [2:0] bitcnt_q;
  logic [7:0] shift_q;
  logic       rw_q;
  logic [6:0] addr_q;
  logic       miso_q;
  logic       miso_oe_q;
  logic       busy_q;
  logic       wr_stb_q;
  logic [6:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] regs_q [DEPTH];

  logic [7:0] mosi_byte_d;
  logic [6:0] addr_inc_d;
  logic [6:0] cmd_addr_d;

  // sclk and cs_n reset to their idle-high level so no edge is seen on reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_FF-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_FF-2:0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_FF-2:0], bus.mosi};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_FF-1];
  assign cs_s      = cs_sync_q[SYNC_FF-1];
  assign mosi_s    = mosi_sync_q[SYNC_FF-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign mosi_byte_d = {shift_q[6:0], mosi_s};
  assign addr_inc_d  = addr_q + 7'd1;
  assign cmd_addr_d  = {shift_q[5:0], mosi_s};

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < DEPTH_B;
  endfunction

  function automatic logic [7:0] rd_reg(input logic [6:0] a);
    return in_range(a) ? regs_q[a[AW-1:0]] : 8'h00;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bitcnt_q  <= 3'd0;
      shift_q   <= 8'h00;
      rw_q      <= 1'b0;
      addr_q    <= 7'd0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 7'd0;
      wr_data_q <= 8'h00;
      regs_q    <= '{default: 8'h00};
    end else begin
      wr_stb_q <= 1'b0;
      // local load first so a same-cycle SPI commit to the same address overrides it
      if (bus.ld_en && in_range(bus.ld_addr)) begin
        regs_q[bus.ld_addr[AW-1:0]] <= bus.ld_data;
      end

      case (state_q)
        IDLE: begin
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          bitcnt_q  <= 3'd0;
          if (!cs_s) begin
            state_q <= CMD;
            busy_q  <= 1'b1;
          end
        end

        CMD: begin
          if (cs_s) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
            bitcnt_q  <= 3'd0;
          end else if (sclk_rise) begin
            shift_q  <= mosi_byte_d;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rw_q     <= shift_q[6];
              addr_q   <= cmd_addr_d;
              state_q  <= DATA;
              bitcnt_q <= 3'd0;
              if (shift_q[6]) begin
                shift_q   <= rd_reg(cmd_addr_d);
                miso_oe_q <= 1'b1;
              end
            end
          end
        end

        DATA: begin
          if (cs_s) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
            bitcnt_q  <= 3'd0;
          end else if (rw_q) begin
            if (sclk_fall) begin
              miso_q   <= shift_q[7];
              shift_q  <= {shift_q[6:0], 1'b0};
              bitcnt_q <= bitcnt_q + 3'd1;
              // last bit of the byte is on miso now; fetch the next byte straight away
              if (bitcnt_q == 3'd7) begin
                addr_q   <= addr_inc_d;
                shift_q  <= rd_reg(addr_inc_d);
                bitcnt_q <= 3'd0;
              end
            end
          end else if (sclk_rise) begin
            shift_q  <= mosi_byte_d;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (in_range(addr_q)) begin
                regs_q[addr_q[AW-1:0]] <= mosi_byte_d;
              end
              wr_stb_q  <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= mosi_byte_d;
              addr_q    <= addr_inc_d;
              bitcnt_q  <= 3'd0;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.miso    = miso_q;
  assign bus.miso_oe = miso_oe_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_rm3100_target.sv
// Directed bench for spi_rm3100_target: frame vector table plus abort, collision,
// mid-frame reset and random clock-phase sequences.
`timescale 1ns/1ps
module tb_spi_rm3100_target;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   phase = 2;

  spi_rm3100_target_if bus();

  spi_rm3100_target #(.DEPTH(16), .SYNC_FF(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  logic [14:0] wr_log[$];
  always @(negedge clk) if (bus.wr_stb) wr_log.push_back({bus.wr_addr, bus.wr_data});

  typedef struct {
    logic [7:0]  cmd;
    int          n;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cs_low();
    @(posedge clk);
    #(phase);
    bus.cs_n = 1'b0;
    #40;
  endtask

  task automatic cs_high();
    bus.cs_n = 1'b1;
    #100;
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output int oe_cnt);
    rx = 8'h00;
    oe_cnt = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.sclk = 1'b0;
      bus.mosi = tx[i];
      #40;
      rx = {rx[6:0], bus.miso};
      if (bus.miso_oe) oe_cnt++;
      bus.sclk = 1'b1;
      #40;
    end
  endtask

  task automatic ld(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ld_addr = a;
    bus.ld_data = d;
    bus.ld_en   = 1'b1;
    @(negedge clk);
    bus.ld_en   = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] rx;
    int         oe;
    logic [6:0] a;
    wr_log.delete();
    cs_low();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    xfer(v.cmd, 8, rx, oe);
    check({tag, "_cmd_oe"}, oe, 0);
    for (int i = 0; i < v.n; i++) begin
      xfer(v.d[31-8*i -: 8], 8, rx, oe);
      if (v.cmd[7]) begin
        check($sformatf("%s_rd%0d", tag, i), 32'(rx), 32'(v.exp[31-8*i -: 8]));
        check($sformatf("%s_rd_oe%0d", tag, i), oe, 8);
      end else begin
        check($sformatf("%s_wr_oe%0d", tag, i), oe, 0);
      end
    end
    cs_high();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_oe"}, 32'(bus.miso_oe), 32'd0);
    if (v.cmd[7]) begin
      check({tag, "_wr_cnt"}, wr_log.size(), 0);
    end else begin
      check({tag, "_wr_cnt"}, wr_log.size(), v.n);
      for (int i = 0; i < v.n && i < wr_log.size(); i++) begin
        a = v.cmd[6:0] + 7'(i);
        check($sformatf("%s_wr%0d", tag, i), 32'(wr_log[i]), 32'({a, v.d[31-8*i -: 8]}));
      end
    end
  endtask

  task automatic collide(input logic [6:0] waddr, input logic [7:0] wdata,
                         input logic [6:0] laddr, input logic [7:0] ldata, input string tag);
    logic [7:0] rx;
    int         oe;
    logic       seen;
    seen = 1'b0;
    wr_log.delete();
    cs_low();
    xfer({1'b0, waddr}, 8, rx, oe);
    fork
      xfer(wdata, 8, rx, oe);
      begin
        repeat (8) @(posedge bus.sclk);
        @(negedge clk);
        bus.ld_addr = laddr;
        bus.ld_data = ldata;
        bus.ld_en   = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          seen = bus.wr_stb;
        end
        bus.ld_en = 1'b0;
      end
    join
    check({tag, "_commit_seen"}, 32'(seen), 32'd1);
    cs_high();
    check({tag, "_wr_cnt"}, wr_log.size(), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       v;
    logic [7:0] rx;
    logic [7:0] acc;
    int         oe;

    vecs[0]  = '{8'h05, 1, 32'hA5000000, 32'h00000000};
    vecs[1]  = '{8'h85, 1, 32'h00000000, 32'hA5000000};
    vecs[2]  = '{8'h8E, 3, 32'h00000000, 32'h11220000};
    vecs[3]  = '{8'h7F, 2, 32'hC33C0000, 32'h00000000};
    vecs[4]  = '{8'h80, 2, 32'h00000000, 32'h3C000000};
    vecs[5]  = '{8'h20, 1, 32'h77000000, 32'h00000000};
    vecs[6]  = '{8'hA0, 2, 32'h00000000, 32'h00000000};
    vecs[7]  = '{8'hC0, 1, 32'h00000000, 32'h00000000};
    vecs[8]  = '{8'h0A, 3, 32'h01020300, 32'h00000000};
    vecs[9]  = '{8'h89, 4, 32'h00000000, 32'h00010203};
    vecs[10] = '{8'h0F, 2, 32'hABCD0000, 32'h00000000};
    vecs[11] = '{8'h8F, 2, 32'h00000000, 32'hAB000000};

    bus.sclk = 1'b1;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.ld_en = 1'b0;
    bus.ld_addr = 7'd0;
    bus.ld_data = 8'h00;

    #3 rst_n = 1'b0;
    #20;
    check("rst_miso", 32'(bus.miso), 32'd0);
    check("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_stb", 32'(bus.wr_stb), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    rst_n = 1'b1;
    #50;

    ld(7'h0E, 8'h11);
    ld(7'h0F, 8'h22);
    ld(7'h00, 8'h33);
    ld(7'h40, 8'h99);
    for (int k = 0; k < 12; k++) run_frame(vecs[k], $sformatf("v%0d", k));

    // abort a write after 5 data bits
    v = '{8'h03, 1, 32'h5A000000, 32'h0};
    run_frame(v, "abort_pre");
    wr_log.delete();
    cs_low();
    xfer(8'h03, 8, rx, oe);
    xfer(8'hFF, 5, rx, oe);
    cs_high();
    check("abort_wr_cnt", wr_log.size(), 0);
    check("abort_busy", 32'(busy), 32'd0);
    v = '{8'h83, 1, 32'h0, 32'h5A000000};
    run_frame(v, "abort_post");

    // local load and SPI commit in the same clock
    collide(7'h02, 8'hAA, 7'h02, 8'h55, "coll_same");
    v = '{8'h82, 1, 32'h0, 32'hAA000000};
    run_frame(v, "coll_same_rd");
    collide(7'h06, 8'h66, 7'h07, 8'h77, "coll_diff");
    v = '{8'h86, 2, 32'h0, 32'h66770000};
    run_frame(v, "coll_diff_rd");

    // reset in the middle of a read data byte
    cs_low();
    xfer(8'h85, 8, rx, oe);
    xfer(8'h00, 3, rx, oe);
    check("mid_oe_before_rst", oe, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", 32'(bus.miso_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    bus.cs_n = 1'b1;
    bus.sclk = 1'b1;
    #20;
    rst_n = 1'b1;
    #100;
    acc = 8'h00;
    cs_low();
    xfer(8'h80, 8, rx, oe);
    for (int i = 0; i < 16; i++) begin
      xfer(8'h00, 8, rx, oe);
      acc = acc | rx;
    end
    cs_high();
    check("mid_rst_regs_zero", 32'(acc), 32'd0);
    v = '{8'h09, 1, 32'h96000000, 32'h0};
    run_frame(v, "post_rst_wr");
    v = '{8'h89, 1, 32'h0, 32'h96000000};
    run_frame(v, "post_rst_rd");

    // random clock phase between the SPI and system clock domains
    ld(7'h0E, 8'h11);
    ld(7'h0F, 8'h22);
    ld(7'h00, 8'h33);
    for (int k = 0; k < 5; k++) begin
      phase = int'($urandom_range(1, 9));
      run_frame(vecs[k], $sformatf("ph_v%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
